// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg -- shared definitions for the multi-cycle MIPS-subset sequencer.
//   state_t  : sequencer state codes (exposed on the 3-bit debug port)
//   iclass_t : instruction classes produced by mc_decode
//   ALU_*    : aluop codes understood by the datapath ALU
//   PC_SRC_* : pc_src mux selects
//   OP_*/FN_*: opcode and R-type funct encodings
// Optional feature macro used by mc_ctrl: MC_CTRL_PERF_CNT_EN
// ---------------------------------------------------------------------------
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE   = 3'd0,
      C_IALU    = 3'd1,
      C_LW      = 3'd2,
      C_SW      = 3'd3,
      C_BEQ     = 3'd4,
      C_JUMP    = 3'd5,
      C_ILLEGAL = 3'd6
   } iclass_t;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_AND = 5'd2;
   localparam logic [4:0] ALU_OR  = 5'd3;
   localparam logic [4:0] ALU_XOR = 5'd4;
   localparam logic [4:0] ALU_SLT = 5'd5;
   localparam logic [4:0] ALU_LUI = 5'd6;

   localparam logic [1:0] PC_SRC_PC4    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mc_ctrl_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_if -- shared instruction/data memory port of the sequencer.
//   mem_req  : request, held high until the memory acknowledges
//   mem_we   : write (sw) qualifier, meaningful only while mem_req is high
//   iord     : address select, 0 = pc, 1 = ALUOut
//   mem_ack  : memory completes the request in this cycle
// Handshake: a transfer completes in every cycle where mem_req and mem_ack
// are both high; mem_req never drops before that except on reset or an ack
// timeout, and mem_ack is ignored while mem_req is low.
// Modports: master = sequencer (mc_ctrl), slave = memory.
// ---------------------------------------------------------------------------
interface mc_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ack;

   modport master (output mem_req, output mem_we, output iord, input mem_ack);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mc_decode.sv
// ---------------------------------------------------------------------------
// mc_decode -- combinational decode of the registered IR fields.
//   op, funct  : IR[31:26], IR[5:0]
//   iclass     : instruction class driving the sequencer's state walk
//   aluop      : ALU_* code for the operation
//   alu_src    : 1 = second ALU operand is the extended immediate
//   if_extend  : 1 = sign-extend the immediate, 0 = zero-extend
//   illegal    : op/funct combination outside the supported subset
// ---------------------------------------------------------------------------
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output logic [4:0] aluop,
   output logic       alu_src,
   output logic       if_extend,
   output logic       illegal
);

   always_comb begin
      iclass    = C_ILLEGAL;
      aluop     = ALU_ADD;
      alu_src   = 1'b0;
      if_extend = 1'b0;
      case (op)
         OP_RTYPE: begin
            iclass = C_RTYPE;
            case (funct)
               FN_ADD:  aluop = ALU_ADD;
               FN_SUB:  aluop = ALU_SUB;
               FN_AND:  aluop = ALU_AND;
               FN_OR:   aluop = ALU_OR;
               FN_XOR:  aluop = ALU_XOR;
               FN_SLT:  aluop = ALU_SLT;
               default: iclass = C_ILLEGAL;
            endcase
         end
         OP_ADDI: begin iclass = C_IALU; aluop = ALU_ADD; alu_src = 1'b1; if_extend = 1'b1; end
         OP_ANDI: begin iclass = C_IALU; aluop = ALU_AND; alu_src = 1'b1; end
         OP_ORI:  begin iclass = C_IALU; aluop = ALU_OR;  alu_src = 1'b1; end
         OP_XORI: begin iclass = C_IALU; aluop = ALU_XOR; alu_src = 1'b1; end
         OP_LUI:  begin iclass = C_IALU; aluop = ALU_LUI; alu_src = 1'b1; end
         OP_LW:   begin iclass = C_LW;   aluop = ALU_ADD; alu_src = 1'b1; if_extend = 1'b1; end
         OP_SW:   begin iclass = C_SW;   aluop = ALU_ADD; alu_src = 1'b1; if_extend = 1'b1; end
         // beq compares two registers; the immediate is still sign-extended
         // so the branch offset path sees the right value.
         OP_BEQ:  begin iclass = C_BEQ;  aluop = ALU_SUB; if_extend = 1'b1; end
         OP_J:    iclass = C_JUMP;
         default: iclass = C_ILLEGAL;
      endcase
      illegal = (iclass == C_ILLEGAL);
   end

endmodule

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle sequencer for the MIPS-subset datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, sharing one
// memory port for instruction and data, and drives every datapath
// enable/select. Strobes are combinational from state + IR decode and last
// one cycle.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   op, funct, zero     : IR fields and ALU zero flag
//   mem (master)        : mem_req/mem_we/iord out, mem_ack in
//   ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
//   alu_src, if_extend, aluop : datapath controls
//   state               : current state code (debug)
//   halted, illegal, bus_err : sticky status, cleared only by reset
// Parameters:
//   ACK_TIMEOUT : max cycles waiting for mem_ack in FETCH/MEM, 0 = never
//   CNT_W       : perf counter width (only with MC_CTRL_PERF_CNT_EN)
// Optional feature macro MC_CTRL_PERF_CNT_EN adds cycle_cnt (non-HALT
// cycles) and instr_cnt (returns to FETCH); both wrap.
// ---------------------------------------------------------------------------
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
`ifdef MC_CTRL_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   mc_ctrl_if.master  mem,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src,
   output logic       if_extend,
   output logic [4:0] aluop,
   output logic [2:0] state,
   output logic       halted,
   output logic       illegal,
   output logic       bus_err
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   // The counter only needs to reach ACK_TIMEOUT-1.
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          illegal_q, illegal_d;
   logic          bus_err_q, bus_err_d;

   iclass_t    dec_class;
   logic [4:0] dec_aluop;
   logic       dec_alu_src;
   logic       dec_if_extend;
   logic       dec_illegal;

   logic req, we, sel_alu, timed_out;

   mc_decode u_decode (
      .op        (op),
      .funct     (funct),
      .iclass    (dec_class),
      .aluop     (dec_aluop),
      .alu_src   (dec_alu_src),
      .if_extend (dec_if_extend),
      .illegal   (dec_illegal)
   );

   // Last un-acked cycle allowed; an ack arriving in this cycle still wins.
   assign timed_out = (ACK_TIMEOUT != 0) && (cnt_q == T_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;            // any cycle that leaves a wait state clears it
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      req        = 1'b0;
      we         = 1'b0;
      sel_alu    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_PC4;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         S_FETCH: begin
            req = 1'b1;
            if (mem.mem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else if (dec_class == C_JUMP) begin
               pc_write = 1'b1;
               pc_src   = PC_SRC_JUMP;
               state_d  = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (dec_class)
               C_LW, C_SW: state_d = S_MEM;
               C_BEQ: begin
                  pc_write = zero;
                  pc_src   = PC_SRC_BRANCH;
                  state_d  = S_FETCH;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            req     = 1'b1;
            sel_alu = 1'b1;
            we      = (dec_class == C_SW);
            if (mem.mem_ack) begin
               state_d = (dec_class == C_SW) ? S_FETCH : S_WB;
            end else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op == OP_RTYPE);
            mem_to_reg = (dec_class == C_LW);
            state_d    = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign mem.mem_req = req;
   assign mem.mem_we  = we;
   assign mem.iord    = sel_alu;

   // ALU controls follow the decoded IR in every live state; the datapath
   // only consumes them in EXEC (and holds ALUOut afterwards).
   assign aluop     = (state_q != S_HALT) ? dec_aluop     : ALU_ADD;
   assign alu_src   = (state_q != S_HALT) && dec_alu_src;
   assign if_extend = (state_q != S_HALT) && dec_if_extend;

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

`ifdef MC_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) instr_cnt_d = instr_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
// Each instruction is expanded into its expected cycle-by-cycle trace from
// the instruction-level rules (which phases it visits, how long each memory
// wait lasts, which controls each phase asserts); the observed outputs are
// queued next to it and compared per test.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

   localparam int ACK_TO = 16;
   localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd5;
   localparam int K_R = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src;
      logic       if_extend;
      logic [4:0] aluop;
      logic       halted;
      logic       illegal;
      logic       bus_err;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [5:0] op = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src, if_extend;
   logic [1:0] pc_src;
   logic [4:0] aluop;
   logic [2:0] state;
   logic       halted, illegal, bus_err;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   mc_ctrl_if mif ();

   mc_ctrl #(.ACK_TIMEOUT(ACK_TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem        (mif),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src    (alu_src),
      .if_extend  (if_extend),
      .aluop      (aluop),
      .state      (state),
      .halted     (halted),
      .illegal    (illegal),
      .bus_err    (bus_err)
`ifdef MC_CTRL_PERF_CNT_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt)
`endif
   );

   vec_t obs;
   assign obs = {state, mif.mem_req, mif.mem_we, mif.iord, ir_write, pc_write, pc_src,
                 reg_write, reg_dst, mem_to_reg, alu_src, if_extend, aluop, halted, illegal, bus_err};

   // ---------------- scoreboard ----------------
   vec_t exp_q[$];
   vec_t msk_q[$];
   vec_t obs_q[$];
   int   tests = 0;
   int   fails = 0;
   int   n_cyc = 0;

   // ---------------- reference rules ----------------
   function automatic int kind(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'b000000: return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010}) ? K_R : K_ILL;
         6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: return K_IALU;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic [4:0] ref_aluop(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'b000000) begin
         case (f)
            6'b100010: return 5'd1;
            6'b100100: return 5'd2;
            6'b100101: return 5'd3;
            6'b100110: return 5'd4;
            6'b101010: return 5'd5;
            default:   return 5'd0;
         endcase
      end
      case (o)
         6'b001100: return 5'd2;
         6'b001101: return 5'd3;
         6'b001110: return 5'd4;
         6'b001111: return 5'd6;
         6'b000100: return 5'd1;
         default:   return 5'd0;
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic do_reset();
      mif.mem_ack = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   // One clock: drive mem_ack, sample outputs, queue expectation + care mask.
   task automatic cyc(input vec_t e, input int k, input logic a);
      vec_t m;
      mif.mem_ack = a;
      #1;
      m = '1;
      if (e.state != ST_E && e.state != ST_W) begin
         m.aluop = '0; m.alu_src = 1'b0; m.if_extend = 1'b0;
      end
      if (k == K_R) m.if_extend = 1'b0;
      if (!e.pc_write && !(e.state == ST_E && k == K_BEQ)) m.pc_src = '0;
      exp_q.push_back(e);
      msk_q.push_back(m);
      obs_q.push_back(obs);
      n_cyc++;
      @(posedge clock); #1;
   endtask

   // Walk one instruction. fw/mw = un-acked cycles before the FETCH/MEM ack;
   // a value >= ACK_TO means the memory never answers.
   task automatic drive_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input int fw, input int mw);
      vec_t b, e;
      int   k;
      k = kind(o, f);
      op = o; funct = f; zero = z;
      b = '0;
      b.aluop     = ref_aluop(o, f);
      b.alu_src   = (k == K_IALU || k == K_LW || k == K_SW);
      b.if_extend = (o == 6'b001000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100);
      for (int i = 0; i <= fw && i < ACK_TO; i++) begin
         e = b; e.state = ST_F; e.mem_req = 1'b1;
         e.ir_write = (i == fw); e.pc_write = (i == fw);
         cyc(e, k, (i == fw));
      end
      if (fw >= ACK_TO) begin
         e = '0; e.state = ST_H; e.halted = 1'b1; e.bus_err = 1'b1;
         cyc(e, k, 1'($urandom_range(0, 1)));
         return;
      end
      e = b; e.state = ST_D;
      if (k == K_J) begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
      cyc(e, k, 1'($urandom_range(0, 1)));
      if (k == K_J) return;
      if (k == K_ILL) begin
         e = '0; e.state = ST_H; e.halted = 1'b1; e.illegal = 1'b1;
         cyc(e, k, 1'($urandom_range(0, 1)));
         return;
      end
      e = b; e.state = ST_E;
      if (k == K_BEQ) begin e.pc_write = z; e.pc_src = 2'd1; end
      cyc(e, k, 1'($urandom_range(0, 1)));
      if (k == K_BEQ) return;
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i <= mw && i < ACK_TO; i++) begin
            e = b; e.state = ST_M; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (k == K_SW);
            cyc(e, k, (i == mw));
         end
         if (mw >= ACK_TO) begin
            e = '0; e.state = ST_H; e.halted = 1'b1; e.bus_err = 1'b1;
            cyc(e, k, 1'($urandom_range(0, 1)));
            return;
         end
         if (k == K_SW) return;
      end
      e = b; e.state = ST_W; e.reg_write = 1'b1;
      e.reg_dst = (o == 6'b000000); e.mem_to_reg = (k == K_LW);
      cyc(e, k, 1'($urandom_range(0, 1)));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      #1;
      tests++; if (state !== ST_F)        begin fails++; $display("FAIL reset_state: got %0d expected %0d", state, ST_F); end
      tests++; if (mif.mem_req !== 1'b1)  begin fails++; $display("FAIL reset_mem_req: got %b expected 1", mif.mem_req); end
      tests++; if (mif.iord !== 1'b0)     begin fails++; $display("FAIL reset_iord: got %b expected 0", mif.iord); end
      tests++; if ({ir_write, pc_write, reg_write, mif.mem_we} !== 4'b0)
                                          begin fails++; $display("FAIL reset_strobes: got %b expected 0000", {ir_write, pc_write, reg_write, mif.mem_we}); end
      tests++; if ({halted, illegal, bus_err} !== 3'b0)
                                          begin fails++; $display("FAIL reset_sticky: got %b expected 000", {halted, illegal, bus_err}); end
`ifdef MC_CTRL_PERF_CNT_EN
      tests++; if ({cycle_cnt, instr_cnt} !== 64'd0) begin fails++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", cycle_cnt, instr_cnt); end
`endif
      @(posedge clock); #1;
      do_reset();
   endtask

   task automatic test_addi();
      vec_t e, m, o;
      int idx = 0;
      do_reset();
      drive_instr(6'b001000, 6'b000101, 1'b0, 2, 0);   // addi $1,$0,5
`ifdef MC_CTRL_PERF_CNT_EN
      tests++; if (cycle_cnt !== 32'd6) begin fails++; $display("FAIL addi_cycle_cnt: got %0d expected 6", cycle_cnt); end
      tests++; if (instr_cnt !== 32'd1) begin fails++; $display("FAIL addi_instr_cnt: got %0d expected 1", instr_cnt); end
`endif
      drive_instr(6'b000010, 6'h00, 1'b0, 0, 0);        // j
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front();
         tests++;
         if (((o ^ e) & m) !== '0) begin fails++; $display("FAIL addi_j_trace[%0d]: got %h expected %h mask %h", idx, o, e, m); end
         idx++;
      end
   endtask

   task automatic test_lw_sw();
      vec_t e, m, o;
      int idx = 0;
      do_reset();
      drive_instr(6'b100011, 6'b000100, 1'b0, 0, 0);    // lw $2,4($1)
      drive_instr(6'b101011, 6'b000100, 1'b0, 0, 3);    // sw with slow memory
      drive_instr(6'b100011, 6'b000100, 1'b0, 15, 15);  // acks on the last allowed cycle
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front();
         tests++;
         if (((o ^ e) & m) !== '0) begin fails++; $display("FAIL lw_sw_trace[%0d]: got %h expected %h mask %h", idx, o, e, m); end
         idx++;
      end
   endtask

   task automatic test_beq();
      vec_t e, m, o;
      int idx = 0;
      do_reset();
      drive_instr(6'b000100, 6'b000011, 1'b1, 0, 0);
      drive_instr(6'b000100, 6'b000011, 1'b0, 1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front();
         tests++;
         if (((o ^ e) & m) !== '0) begin fails++; $display("FAIL beq_trace[%0d]: got %h expected %h mask %h", idx, o, e, m); end
         idx++;
      end
   endtask

   task automatic test_random_stream();
      vec_t e, m, o;
      logic [5:0] ops [0:9];
      logic [5:0] fns [0:5];
      logic [5:0] so, sf;
      int idx = 0;
      int c0;
      int n_instr = 0;
      ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110,
              6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
      do_reset();
      c0 = n_cyc;
      for (int n = 0; n < 60; n++) begin
         so = ops[$urandom_range(0, 9)];
         sf = (so == 6'b000000) ? fns[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
         drive_instr(so, sf, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 15),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 15));
         n_instr++;
      end
`ifdef MC_CTRL_PERF_CNT_EN
      tests++; if (cycle_cnt !== 32'(n_cyc - c0)) begin fails++; $display("FAIL rand_cycle_cnt: got %0d expected %0d", cycle_cnt, n_cyc - c0); end
      tests++; if (instr_cnt !== 32'(n_instr))    begin fails++; $display("FAIL rand_instr_cnt: got %0d expected %0d", instr_cnt, n_instr); end
`else
      c0 = c0 + n_instr;
`endif
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front();
         tests++;
         if (((o ^ e) & m) !== '0) begin fails++; $display("FAIL rand_trace[%0d]: got %h expected %h mask %h", idx, o, e, m); end
         idx++;
      end
   endtask

   task automatic test_timeout();
      vec_t e, m, o;
      int idx = 0;
      do_reset();
      drive_instr(6'b001000, 6'h00, 1'b0, ACK_TO, 0);        // fetch never acked
      do_reset();
      drive_instr(6'b100011, 6'h00, 1'b0, 0, ACK_TO);        // load never acked
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front();
         tests++;
         if (((o ^ e) & m) !== '0) begin fails++; $display("FAIL timeout_trace[%0d]: got %h expected %h mask %h", idx, o, e, m); end
         idx++;
      end
   endtask

   task automatic test_illegal();
      vec_t e, m, o;
      int idx = 0;
      do_reset();
      drive_instr(6'b111111, 6'h00, 1'b0, 1, 0);
      for (int i = 0; i < 19; i++) begin
         e = '0; e.state = ST_H; e.halted = 1'b1; e.illegal = 1'b1;
         cyc(e, K_ILL, 1'($urandom_range(0, 1)));
      end
      do_reset();
      drive_instr(6'b000000, 6'b000001, 1'b0, 0, 0);          // bad R funct
      do_reset();
      drive_instr(6'b000000, 6'b100000, 1'b0, 0, 0);          // add runs after reset
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front();
         tests++;
         if (((o ^ e) & m) !== '0) begin fails++; $display("FAIL illegal_trace[%0d]: got %h expected %h mask %h", idx, o, e, m); end
         idx++;
      end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      op = 6'b101011; funct = 6'h08; zero = 1'b0;
      mif.mem_ack = 1'b1;
      @(posedge clock); #1;
      mif.mem_ack = 1'b0;
      repeat (5) begin @(posedge clock); #1; end
      tests++; if ({state, mif.mem_req, mif.mem_we, mif.iord} !== {ST_M, 3'b111})
         begin fails++; $display("FAIL mid_mem_before: got %b expected %b", {state, mif.mem_req, mif.mem_we, mif.iord}, {ST_M, 3'b111}); end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      tests++; if ({state, mif.mem_req, mif.mem_we, mif.iord} !== {ST_F, 3'b100})
         begin fails++; $display("FAIL mid_mem_after: got %b expected %b", {state, mif.mem_req, mif.mem_we, mif.iord}, {ST_F, 3'b100}); end
      tests++; if ({halted, illegal, bus_err} !== 3'b0)
         begin fails++; $display("FAIL mid_mem_sticky: got %b expected 000", {halted, illegal, bus_err}); end
`ifdef MC_CTRL_PERF_CNT_EN
      tests++; if ({cycle_cnt, instr_cnt} !== 64'd0) begin fails++; $display("FAIL mid_mem_perf: got %0d/%0d expected 0/0", cycle_cnt, instr_cnt); end
`endif
      @(posedge clock); #1;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      mif.mem_ack = 1'b0;
      test_reset();
      test_addi();
      test_lw_sw();
      test_beq();
      test_random_stream();
      test_timeout();
      test_illegal();
      test_reset_mid_mem();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
